// File: rtl/prog_memory_loader.sv
// Program memory with a debounced pushbutton loader that assembles instruction
// words chunk by chunk, plus a registered, clock-enabled fetch port.
module prog_memory_loader #(
  parameter int DATA_W       = 16,
  parameter int CHUNK_W      = 4,
  parameter int ADDR_W       = 6,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                button,
  input  logic [CHUNK_W-1:0]                  instruction,
  input  logic                                load_mode,
  input  logic                                clk_enable,
  input  logic [ADDR_W-1:0]                   read_address,
  output logic [DATA_W-1:0]                   instruction_out,
  output logic [DATA_W-1:0]                   led_ins,
  output logic [$clog2(DATA_W/CHUNK_W)-1:0]   chunk_idx,
  output logic [ADDR_W:0]                     load_count,
  output logic                                full
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int CIW    = $clog2(NCHUNK);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int DCW    = $clog2(DEBOUNCE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_FULL
  } state_t;

  logic             r_sync1;
  logic             r_sync;
  logic             r_flt;
  logic             r_flt_d;
  logic [DCW-1:0]   r_dcnt;

  state_t           r_state;
  logic [DATA_W-1:0] r_asm;
  logic [CIW-1:0]   r_chunk_idx;
  logic [ADDR_W:0]  r_load_count;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic             w_stb;
  logic             w_abort;
  logic             w_accept;
  logic             w_last;
  logic             w_wr_en;
  logic [DATA_W-1:0] w_next_word;

  // Synchroniser and debounce: a new level must persist DEBOUNCE_CYC cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync  <= 1'b0;
      r_flt   <= 1'b0;
      r_flt_d <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync1 <= button;
      r_sync  <= r_sync1;
      r_flt_d <= r_flt;
      if (r_sync == r_flt) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCW'(DEBOUNCE_CYC - 1)) begin
        r_flt  <= r_sync;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DCW'(1);
      end
    end
  end

  assign w_stb       = r_flt & ~r_flt_d;
  assign w_abort     = ~load_mode & (r_chunk_idx != '0);
  // load_mode low already blocks acceptance, so an abort always wins over a strobe.
  assign w_accept    = w_stb & load_mode & (r_state != S_FULL);
  assign w_last      = (r_chunk_idx == CIW'(NCHUNK - 1));
  assign w_wr_en     = w_accept & w_last;
  assign w_next_word = {r_asm[DATA_W-CHUNK_W-1:0], instruction};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_asm        <= '0;
      r_chunk_idx  <= '0;
      r_load_count <= '0;
    end else if (w_abort) begin
      r_state     <= S_IDLE;
      r_asm       <= '0;
      r_chunk_idx <= '0;
    end else if (w_accept) begin
      r_asm <= w_next_word;
      if (w_last) begin
        r_chunk_idx  <= '0;
        r_load_count <= r_load_count + (ADDR_W+1)'(1);
        r_state      <= (r_load_count == (ADDR_W+1)'(DEPTH - 1)) ? S_FULL : S_IDLE;
      end else begin
        r_chunk_idx <= r_chunk_idx + CIW'(1);
        r_state     <= S_ASSEMBLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_load_count[ADDR_W-1:0]] <= w_next_word;
    end
  end

  // Read-first: a same-edge write is not visible until the following enabled edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (clk_enable) begin
      r_rdata <= r_mem[read_address];
    end
  end

  assign instruction_out = r_rdata;
  assign led_ins         = r_asm;
  assign chunk_idx       = r_chunk_idx;
  assign load_count      = r_load_count;
  assign full            = (r_state == S_FULL);

endmodule

// File: tb/tb_prog_memory_loader.sv
// Scoreboard bench for prog_memory_loader: stimulus pushes expected captures and
// reads into queues; a monitor pops them whenever the DUT outputs change or a read completes.
module tb_prog_memory_loader;

  localparam int DW    = 16;
  localparam int CW    = 4;
  localparam int AW    = 2;
  localparam int DEB   = 4;
  localparam int NCH   = DW / CW;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          button = 1'b0;
  logic [CW-1:0] instruction = '0;
  logic          load_mode = 1'b0;
  logic          clk_enable = 1'b0;
  logic [AW-1:0] read_address = '0;
  logic [DW-1:0] instruction_out;
  logic [DW-1:0] led_ins;
  logic [1:0]    chunk_idx;
  logic [AW:0]   load_count;
  logic          full;

  prog_memory_loader #(
    .DATA_W(DW),
    .CHUNK_W(CW),
    .ADDR_W(AW),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .button(button),
    .instruction(instruction),
    .load_mode(load_mode),
    .clk_enable(clk_enable),
    .read_address(read_address),
    .instruction_out(instruction_out),
    .led_ins(led_ins),
    .chunk_idx(chunk_idx),
    .load_count(load_count),
    .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] led;
    int            idx;
    int            lc;
    bit            fl;
    int            at;
  } cap_t;

  cap_t          cap_q[$];
  logic [DW-1:0] rd_q[$];

  int n_err = 0;
  int n_checks = 0;

  // Behavioural model of the loader, in terms of words and presses.
  logic [DW-1:0] m_asm = '0;
  int            m_idx = 0;
  int            m_lc = 0;
  logic [DW-1:0] m_mem [DEPTH];

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit m_full();
    return m_lc == DEPTH;
  endfunction

  function automatic void push_state(int at);
    cap_t c;
    c.led = m_asm;
    c.idx = m_idx;
    c.lc  = m_lc;
    c.fl  = m_full();
    c.at  = at;
    cap_q.push_back(c);
  endfunction

  // Monitor: an output change means the DUT committed a chunk or an abort.
  initial begin
    logic [DW+2+AW+1:0] cur, prev;
    bit en_s;
    bit primed = 0;
    cap_t c;
    forever begin
      @(posedge clk);
      en_s = clk_enable;
      @(negedge clk);
      cur = {led_ins, chunk_idx, load_count, full};
      if (reset || !primed) begin
        primed = 1;
      end else begin
        if (cur != prev) begin
          if (cap_q.size() == 0) begin
            chk("unexpected_output_change", longint'(cur), longint'(prev));
          end else begin
            c = cap_q.pop_front();
            chk("led_ins", led_ins, c.led);
            chk("chunk_idx", chunk_idx, c.idx);
            chk("load_count", load_count, c.lc);
            chk("full", full, c.fl);
            chk("capture_cycle", cyc, c.at);
          end
        end
        if (en_s) begin
          if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
          else chk("instruction_out", instruction_out, rd_q.pop_front());
        end
      end
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic press(input logic [CW-1:0] ch, input bit rdw);
    int c0;
    int waddr;
    logic [DW-1:0] oldw;
    @(posedge clk); #1;
    c0 = cyc;
    instruction = ch;
    button = 1'b1;
    waddr = m_lc;
    oldw = m_mem[waddr % DEPTH];
    if (load_mode && !m_full()) begin
      m_asm = (m_asm << CW) | DW'(ch);
      m_idx++;
      if (m_idx == NCH) begin
        m_mem[m_lc] = m_asm;
        m_lc++;
        m_idx = 0;
      end
      push_state(c0 + 3 + DEB);
    end
    if (rdw) begin
      rd_q.push_back(oldw);
      rd_q.push_back(m_mem[waddr % DEPTH]);
    end
    for (int j = 1; j <= DEB + 4; j++) begin
      @(posedge clk); #1;
      if (rdw && j == DEB + 2) begin
        read_address = AW'(waddr);
        clk_enable = 1'b1;
      end
      if (rdw && j == DEB + 4) clk_enable = 1'b0;
    end
    button = 1'b0;
    repeat (DEB + 4) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic press_word(input logic [DW-1:0] w, input bit rdw_last);
    for (int i = NCH - 1; i >= 0; i--) begin
      press(CW'(w >> (i * CW)), rdw_last && i == 0);
    end
  endtask

  task automatic read_at(input int a);
    @(posedge clk); #1;
    read_address = AW'(a);
    clk_enable = 1'b1;
    rd_q.push_back(m_mem[a]);
    @(posedge clk); #1;
    clk_enable = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("rst_instruction_out", instruction_out, 0);
    chk("rst_led_ins", led_ins, 0);
    chk("rst_chunk_idx", chunk_idx, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_full", full, 0);
    m_asm = '0;
    m_idx = 0;
    m_lc = 0;
    @(posedge clk); #3;
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    do_reset();
    load_mode = 1'b1;

    // Basic load and fetch.
    press(4'hA, 0);
    press(4'hB, 0);
    press(4'hC, 0);
    press(4'hD, 0);
    read_at(0);
    @(posedge clk); #1;
    read_address = 2'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_instruction_out", instruction_out, m_mem[0]);

    // Short bursts must never register, then a clean press does exactly once.
    for (int unsigned len = 1; len < DEB; len++) begin
      @(posedge clk); #1;
      instruction = CW'($urandom_range(0, 15));
      button = 1'b1;
      repeat (len) @(posedge clk);
      #1;
      button = 1'b0;
      repeat (DEB + 4) @(posedge clk);
    end
    press(4'h5, 0);
    for (int unsigned i = 0; i < NCH - 1; i++) press(CW'($urandom_range(0, 15)), 0);
    read_at(1);

    // Abort a partial word, then an ignored strobe with load_mode low.
    press(4'h7, 0);
    press(4'h8, 0);
    @(posedge clk); #1;
    load_mode = 1'b0;
    m_asm = '0;
    m_idx = 0;
    push_state(cyc + 1);
    @(posedge clk); #1;
    load_mode = 1'b1;
    load_mode = 1'b0;
    press(CW'($urandom_range(0, 15)), 0);
    load_mode = 1'b1;
    press_word(16'h1234, 0);
    press_word(DW'($urandom), 0);

    // Presses while full are ignored.
    for (int unsigned i = 0; i < 4; i++) press(CW'($urandom_range(0, 15)), 0);
    for (int a = 0; a < DEPTH; a++) read_at(a);

    // Reset while full, reset mid-word, then read-during-write at address 0.
    do_reset();
    press(CW'($urandom_range(0, 15)), 0);
    press(CW'($urandom_range(0, 15)), 0);
    do_reset();
    w = m_mem[0] ^ 16'h5A5A;
    press_word(w, 1);
    read_at(1);

    repeat (4) @(posedge clk);
    #1;
    chk("cap_queue_drained", cap_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
